ahb_master_req_gen: RTL

AHB_MASTER_REQ_GEN -- requirements
Module: ahb_master_req_gen

---
 rtl/ahb_master_req_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ahb_master_req_gen.sv
// rtl/ahb_master_req_gen.sv - AHB master-side request generator for a per-slave arbiter fabric
//
// Decodes the target slave from the top address bits of each NONSEQ transfer,
// raises a registered one-hot request toward that slave's arbiter, and turns
// the arbiter's grant into hready for the master. It also counts burst beats
// so the final accepted beat is flagged on hlast.
//
// Ports:
//   hclk      in   clock, rising edge
//   hreset_n  in   asynchronous active-low reset
//   htrans    in   [1:0] transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//   haddr     in   [ADDR_W-1:0] master address; top SLAVE_BIT bits select the slave
//   hburst    in   [2:0] burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3,
//                  WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
//   hreq      out  [SLAVE_NUM-1:0] registered one-hot request to slave arbiters
//   hgrant    in   [SLAVE_NUM-1:0] per-slave grant; only the targeted bit is used
//   hready    out  beat completes this cycle (combinational from hgrant)
//   hsel_idx  out  [SLAVE_BIT-1:0] latched target slave index
//   hlast     out  pulses on the accepted final beat of a transaction

module ahb_master_req_gen #(
  parameter int SLAVE_NUM = 4,
  parameter int ADDR_W    = 32,
  parameter int SLAVE_BIT = $clog2(SLAVE_NUM)
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  input  logic [1:0]           htrans,
  input  logic [ADDR_W-1:0]    haddr,
  input  logic [2:0]           hburst,
  output logic [SLAVE_NUM-1:0] hreq,
  input  logic [SLAVE_NUM-1:0] hgrant,
  output logic                 hready,
  output logic [SLAVE_BIT-1:0] hsel_idx,
  output logic                 hlast
);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;
  localparam logic [2:0] BURST_WRAP8  = 3'd4;
  localparam logic [2:0] BURST_INCR8  = 3'd5;
  localparam logic [2:0] BURST_WRAP16 = 3'd6;
  localparam logic [2:0] BURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // Beats after the first one; INCR returns 0 but is handled as unbounded.
  function automatic logic [3:0] beat_limit(input logic [2:0] burst);
    case (burst)
      BURST_WRAP4,  BURST_INCR4:  beat_limit = 4'd3;
      BURST_WRAP8,  BURST_INCR8:  beat_limit = 4'd7;
      BURST_WRAP16, BURST_INCR16: beat_limit = 4'd15;
      default:                    beat_limit = 4'd0;
    endcase
  endfunction

  state_t                 state, state_n;
  logic [SLAVE_BIT-1:0]   idx_n;
  logic [2:0]             burst_q, burst_n;
  logic [3:0]             cnt, cnt_n;
  logic [SLAVE_NUM-1:0]   hreq_n;
  logic                   relatch;
  logic                   granted;
  logic                   unbounded;
  logic [3:0]             limit;
  logic [SLAVE_BIT-1:0]   new_idx;

  // Low address bits carry no routing information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^haddr[ADDR_W-SLAVE_BIT-1:0];

  assign new_idx   = haddr[ADDR_W-1 -: SLAVE_BIT];
  assign granted   = hgrant[hsel_idx];
  assign unbounded = (burst_q == BURST_INCR);
  assign limit     = beat_limit(burst_q);

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state    <= ST_IDLE;
      hsel_idx <= '0;
      burst_q  <= BURST_SINGLE;
      cnt      <= 4'd0;
      hreq     <= '0;
    end else begin
      state    <= state_n;
      hsel_idx <= idx_n;
      burst_q  <= burst_n;
      cnt      <= cnt_n;
      hreq     <= hreq_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = hsel_idx;
    burst_n = burst_q;
    cnt_n   = cnt;
    hready  = 1'b1;
    hlast   = 1'b0;
    relatch = 1'b0;
    hreq_n  = '0;

    case (state)
      ST_IDLE: begin
        if (htrans == TRANS_NONSEQ) relatch = 1'b1;
      end

      ST_REQ: begin
        hready = granted;
        if (granted) begin
          // A SINGLE completes with its first granted beat, even if the
          // master is already presenting the next NONSEQ.
          if (!unbounded && limit == 4'd0) hlast = 1'b1;
          if (htrans == TRANS_NONSEQ)                relatch = 1'b1;
          else if (!unbounded && limit == 4'd0)      state_n = ST_IDLE;
          else                                       state_n = ST_XFER;
        end
      end

      ST_XFER: begin
        hready = granted;
        if (granted) begin
          case (htrans)
            TRANS_NONSEQ: relatch = 1'b1;
            TRANS_IDLE:   state_n = ST_IDLE;
            TRANS_SEQ: begin
              // The counter tracks SEQ beats after the first, so the final
              // beat is the one seen with cnt == limit-1.
              if (!unbounded && cnt == limit - 4'd1) begin
                hlast   = 1'b1;
                state_n = ST_IDLE;
              end else if (cnt != 4'hF) begin
                cnt_n = cnt + 4'd1;
              end
            end
            TRANS_BUSY:   ;
            default:      ;
          endcase
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (relatch) begin
      idx_n   = new_idx;
      burst_n = hburst;
      cnt_n   = 4'd0;
      state_n = ST_REQ;
    end

    // Request register follows the next state, so a back-to-back NONSEQ
    // moves the one-hot bit without a zero cycle.
    if (state_n != ST_IDLE) hreq_n[idx_n] = 1'b1;
  end

endmodule
